matrix_reader: RTL and testbench

Input-side loader for parallel_matrix_multiplier, the counterpart of the result writer. It accepts a stream of 32-bit words under a valid/ready handshake and fills two n x n operand buffers: A first, then B, each in row-major order. It then serves elements to the multiplier through indexed read ports with one cycle of latency. It signals done once both matrices are complete.

---
 rtl/matrix_reader.sv | 112 +++++++++++
 tb/tb_matrix_reader.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/matrix_reader.sv
// matrix_reader: streams n*n words into operand buffer A, then n*n words into
// buffer B (both row-major), and serves both buffers through registered
// indexed read ports for the matrix multiplier.
//
// state   | meaning
// --------+----------------------------------------------
// IDLE    | waiting for start, input not accepted
// LOAD_A  | accepting words into A in row-major order
// LOAD_B  | accepting words into B in row-major order
// DONE    | both buffers complete, waiting for a restart
module matrix_reader #(
  parameter int n     = 4,
  parameter int width = 32,
  parameter int n_len = $clog2(n)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  input  logic [width-1:0] in_data,
  output logic             in_ready,
  input  logic [n_len-1:0] a_i,
  input  logic [n_len-1:0] a_j,
  output logic [width-1:0] a_out,
  input  logic [n_len-1:0] b_i,
  input  logic [n_len-1:0] b_j,
  output logic [width-1:0] b_out,
  output logic             busy,
  output logic             done
);

  localparam logic [1:0] st_idle   = 2'd0;
  localparam logic [1:0] st_load_a = 2'd1;
  localparam logic [1:0] st_load_b = 2'd2;
  localparam logic [1:0] st_done   = 2'd3;

  localparam logic [n_len:0] last_idx = (n_len + 1)'(n - 1);

  logic [1:0]       state;
  logic [n_len:0]   row;
  logic [n_len:0]   col;
  logic             accept;
  logic             last_elem;

  logic [width-1:0] mem_a [n][n];
  logic [width-1:0] mem_b [n][n];

  // Ready depends only on the state so upstream can never form a loop through in_valid.
  always_comb begin
    in_ready  = (state == st_load_a) || (state == st_load_b);
    busy      = in_ready;
    done      = (state == st_done);
    accept    = in_valid & in_ready;
    last_elem = (row == last_idx) && (col == last_idx);
  end

  // Load sequencer: state and row/column position of the next word.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= st_idle;
      row   <= '0;
      col   <= '0;
    end else begin
      case (state)
        st_idle, st_done: begin
          if (start) begin
            state <= st_load_a;
            row   <= '0;
            col   <= '0;
          end
        end
        st_load_a, st_load_b: begin
          if (accept) begin
            if (last_elem) begin
              row   <= '0;
              col   <= '0;
              state <= (state == st_load_a) ? st_load_b : st_done;
            end else if (col == last_idx) begin
              col <= '0;
              row <= row + 1'b1;
            end else begin
              col <= col + 1'b1;
            end
          end
        end
        default: state <= st_idle;
      endcase
    end
  end

  // Buffer writes; contents survive reset, but no write lands during a reset cycle.
  always_ff @(posedge clk) begin
    if (!rst && accept) begin
      if (state == st_load_a)
        mem_a[row[n_len-1:0]][col[n_len-1:0]] <= in_data;
      else
        mem_b[row[n_len-1:0]][col[n_len-1:0]] <= in_data;
    end
  end

  // Registered read ports; a same-cycle write is seen one cycle later (old data first).
  always_ff @(posedge clk) begin
    if (rst) begin
      a_out <= '0;
      b_out <= '0;
    end else begin
      a_out <= mem_a[a_i][a_j];
      b_out <= mem_b[b_i][b_j];
    end
  end

endmodule

// File: tb/tb_matrix_reader.sv
// Directed-plus-random bench for matrix_reader with a reference model that
// tracks the load as a count of accepted words into plain 2D arrays.
module tb_matrix_reader;
  localparam int N  = 4;
  localparam int NN = N * N;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic [1:0]  a_i, a_j, b_i, b_j;
  logic [31:0] a_out, b_out;
  logic        busy, done;

  matrix_reader #(.n(N), .width(32)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .a_i(a_i), .a_j(a_j), .a_out(a_out),
    .b_i(b_i), .b_j(b_j), .b_out(b_out), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int busy_cnt = 0;

  // reference model
  logic [31:0] ref_a [N][N];
  logic [31:0] ref_b [N][N];
  bit          m_loading = 1'b0;
  bit          m_done = 1'b0;
  int          m_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs at the falling edge, check status, advance the model.
  task automatic cyc(input logic v, input logic [31:0] d, input logic s, input logic r);
    in_valid = v;
    in_data  = d;
    start    = s;
    rst      = r;
    #1;
    chk("in_ready", {31'd0, in_ready}, {31'd0, m_loading});
    chk("busy",     {31'd0, busy},     {31'd0, m_loading});
    chk("done",     {31'd0, done},     {31'd0, m_done});
    if (busy === 1'b1) busy_cnt++;
    if (r) begin
      m_loading = 1'b0;
      m_done    = 1'b0;
    end else if (m_loading) begin
      if (v) begin
        if (m_cnt < NN) ref_a[m_cnt / N][m_cnt % N] = d;
        else            ref_b[(m_cnt - NN) / N][(m_cnt - NN) % N] = d;
        m_cnt++;
        if (m_cnt == 2 * NN) begin
          m_loading = 1'b0;
          m_done    = 1'b1;
        end
      end
    end else if (s) begin
      m_loading = 1'b1;
      m_done    = 1'b0;
      m_cnt     = 0;
    end
    @(negedge clk);
    in_valid = 1'b0;
    start    = 1'b0;
    rst      = 1'b0;
  endtask

  task automatic read_all(input string tag);
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        a_i = 2'(i); a_j = 2'(j); b_i = 2'(i); b_j = 2'(j);
        cyc(1'b0, 32'd0, 1'b0, 1'b0);
        chk({tag, "_a"}, a_out, ref_a[i][j]);
        chk({tag, "_b"}, b_out, ref_b[i][j]);
      end
    end
  endtask

  function automatic logic [31:0] seq_word(input int k);
    return (k < NN) ? 32'(k + 1) : 32'(101 + k - NN);
  endfunction

  initial begin
    logic [31:0] old00, old11, w;
    int guard;
    int k;

    start = 1'b0; in_valid = 1'b0; in_data = '0;
    a_i = '0; a_j = '0; b_i = '0; b_j = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_a_out", a_out, 32'd0);
    chk("rst_b_out", b_out, 32'd0);
    rst = 1'b0;
    repeat (3) cyc(1'b0, 32'd0, 1'b0, 1'b0);

    // Scenario 1: back-to-back stream 1..16, 101..116
    cyc(1'b0, 32'd0, 1'b1, 1'b0);
    busy_cnt = 0;
    for (int q = 0; q < 2 * NN; q++) cyc(1'b1, seq_word(q), 1'b0, 1'b0);
    cyc(1'b0, 32'd0, 1'b0, 1'b0);
    chk("done_after_32", {31'd0, done}, 32'd1);
    chk("busy_cycles", 32'(busy_cnt), 32'd32);
    a_i = 2'd2; a_j = 2'd3; b_i = 2'd0; b_j = 2'd1;
    cyc(1'b0, 32'd0, 1'b0, 1'b0);
    chk("a23", a_out, 32'd12);
    chk("b01", b_out, 32'd102);

    // Scenario 2: same stream, valid on every other cycle
    cyc(1'b0, 32'd0, 1'b1, 1'b0);
    for (int q = 0; q < 4 * NN; q++)
      cyc(q % 2 == 0, (q % 2 == 0) ? seq_word(q / 2) : 32'hBAD0_0000, 1'b0, 1'b0);
    chk("done_gapped", {31'd0, done}, 32'd1);
    read_all("gapped");

    // Scenario 3: start mid-load ignored, then data while DONE is dropped
    cyc(1'b0, 32'd0, 1'b1, 1'b0);
    k = 0;
    guard = 0;
    while (m_loading && guard < 500) begin
      w = $urandom;
      cyc(($urandom % 3) != 0, w, (k == 5), 1'b0);
      k = m_cnt;
      guard++;
    end
    chk("mid_start_done", {31'd0, done}, 32'd1);
    for (int q = 0; q < 6; q++) cyc(1'b1, $urandom, 1'b0, 1'b0);
    read_all("done_drop");

    // Scenario 4: reset after 20 accepts, then reload all 7s
    cyc(1'b0, 32'd0, 1'b1, 1'b0);
    for (int q = 0; q < 20; q++) cyc(1'b1, $urandom, 1'b0, 1'b0);
    cyc(1'b0, 32'd0, 1'b0, 1'b1);
    cyc(1'b0, 32'd0, 1'b0, 1'b0);
    cyc(1'b0, 32'd0, 1'b1, 1'b0);
    for (int q = 0; q < 2 * NN; q++) cyc(1'b1, 32'd7, 1'b0, 1'b0);
    read_all("sevens");

    // Scenario 5: restart from DONE, read-during-write on A[0][0]
    cyc(1'b0, 32'd0, 1'b1, 1'b0);
    for (int q = 0; q < 2 * NN; q++) cyc(1'b1, $urandom, 1'b0, 1'b0);
    old00 = ref_a[0][0];
    old11 = ref_a[1][1];
    a_i = 2'd0; a_j = 2'd0;
    cyc(1'b0, 32'd0, 1'b1, 1'b0);
    w = old00 ^ 32'hA5A5_0001;
    cyc(1'b1, w, 1'b0, 1'b0);
    chk("rdw_old", a_out, old00);
    cyc(1'b0, 32'd0, 1'b0, 1'b0);
    chk("rdw_new", a_out, w);
    a_i = 2'd1; a_j = 2'd1;
    cyc(1'b0, 32'd0, 1'b0, 1'b0);
    chk("a11_stale", a_out, old11);
    guard = 0;
    while (m_loading && guard < 500) begin
      cyc(($urandom % 2) != 0, $urandom, 1'b0, 1'b0);
      guard++;
    end
    chk("reload_done", {31'd0, done}, 32'd1);
    read_all("reload");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
